// File: rtl/burst_fetch.sv
// Read-side burst initiator: issues 1/4/8/16-word memory reads and streams the
// returned words, tagged with address and last flag, through a FWFT FIFO.
module burst_fetch #(
  parameter int                       data_width    = 32,
  parameter int                       address_width = 32,
  parameter logic [address_width-1:0] start_addr    = 32'h80020000,
  parameter int                       mem_bytes     = 1048576,
  parameter int                       fifo_depth    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [address_width-1:0] req_addr,
  input  logic [1:0]               req_size,
  output logic                     req_ready,
  output logic                     req_err,
  output logic [address_width-1:0] mem_address,
  output logic [1:0]               mem_access_size,
  output logic                     mem_rw,
  output logic                     mem_enable,
  input  logic                     mem_busy,
  input  logic [data_width-1:0]    mem_data_out,
  output logic                     word_valid,
  output logic [data_width-1:0]    word_data,
  output logic [address_width-1:0] word_addr,
  output logic                     word_last,
  input  logic                     word_ready,
  output logic                     state_dbg
);

  localparam int ptr_w   = $clog2(fifo_depth);
  localparam int cnt_w   = ptr_w + 1;
  localparam int entry_w = address_width + data_width + 1;
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [address_width-1:0] base_q, base_d;
  logic [1:0]               size_q, size_d;
  logic [4:0]               beat_q, beat_d;
  logic                     err_q, err_d;
  logic [ptr_w-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]         count_q, count_d;
  logic [entry_w-1:0]       fifo_mem [fifo_depth];

  logic [4:0]       req_len, act_len;
  logic [cnt_w-1:0] free_w;
  logic             space_ok, accept, bad_req, capture, last_beat, pop;
  logic [32:0]      offset_w, span_w;

  function automatic logic [4:0] burst_len(input logic [1:0] s);
    case (s)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Range check in 33 bits so the end of the burst can never wrap past 2^32.
  always_comb begin
    req_len  = burst_len(req_size);
    act_len  = burst_len(size_q);
    free_w   = depth_c - count_q;
    space_ok = free_w >= cnt_w'(req_len);
    offset_w = {1'b0, req_addr} - {1'b0, start_addr};
    span_w   = offset_w + 33'({req_len, 2'b00});
    bad_req  = (req_addr[1:0] != 2'b00) || (req_addr < start_addr) ||
               (span_w > 33'(mem_bytes));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= start_addr;
      size_q   <= 2'b00;
      beat_q   <= 5'd0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      size_q   <= size_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    size_d  = size_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            state_d = BURST;
            base_d  = req_addr;
            size_d  = req_size;
            beat_d  = 5'd0;
          end
        end
      end
      BURST: begin
        if (capture) begin
          beat_d = beat_q + 5'd1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state_q == IDLE) && space_ok;
    accept          = req_valid && req_ready;
    req_err         = err_q;
    mem_enable      = (state_q == BURST);
    mem_rw          = 1'b1;
    mem_address     = base_q + address_width'({beat_q, 2'b00});
    mem_access_size = size_q;
    capture         = (state_q == BURST) && !mem_busy;
    last_beat       = (beat_q == act_len - 5'd1);
    state_dbg       = state_q;
  end

  // FIFO bookkeeping; admission control guarantees a push never meets a full FIFO.
  always_comb begin
    word_valid = (count_q != '0);
    pop        = word_valid && word_ready;
    wr_ptr_d   = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (capture && !pop) count_d = count_q + 1'b1;
    else if (!capture && pop) count_d = count_q - 1'b1;
    {word_addr, word_data, word_last} = word_valid ? fifo_mem[rd_ptr_q] : '0;
  end

  always_ff @(posedge clock) begin
    if (capture) fifo_mem[wr_ptr_q] <= {mem_address, mem_data_out, last_beat};
  end

endmodule

// File: tb/tb_burst_fetch.sv
// Directed bench for burst_fetch: a transaction-level model with an expected-word
// queue is checked every cycle, plus literal expectations for the directed cases.
module tb_burst_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_err;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] mem_address, mem_data_out;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable, mem_busy;
  logic        word_valid, word_last, word_ready, state_dbg;
  logic [31:0] word_data, word_addr;

  int n_vec = 0;
  int n_bad = 0;
  int err_count = 0;

  always #5 clock = ~clock;

  burst_fetch dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_ready(req_ready), .req_err(req_err),
    .mem_address(mem_address), .mem_access_size(mem_access_size),
    .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy),
    .mem_data_out(mem_data_out),
    .word_valid(word_valid), .word_data(word_data), .word_addr(word_addr),
    .word_last(word_last), .word_ready(word_ready), .state_dbg(state_dbg)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80020000) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A3C, a[31:16] + a[15:0]};
  endfunction

  assign mem_data_out = mem_word(mem_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [64:0] exp_q[$];
  logic [64:0] pop_log[$];
  bit          m_burst, m_err, m_rdy, m_pop, m_push;
  logic [31:0] m_base;
  logic [1:0]  m_size;
  int          m_len, m_beat;
  logic [64:0] m_ent;
  logic [31:0] m_a;

  function automatic int len_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 4 : (s == 2'd2) ? 8 : 16;
  endfunction

  function automatic bit m_ready();
    return !m_burst && ((32 - exp_q.size()) >= len_of(req_size));
  endfunction

  function automatic bit m_bad(input logic [31:0] a, input logic [1:0] s);
    logic [63:0] off;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < 32'h80020000) return 1'b1;
    off = {32'b0, a} - 64'h80020000;
    return (off + 64'(4 * len_of(s))) > 64'd1048576;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_burst = 0; m_err = 0; m_base = 32'h80020000; m_size = 2'd0;
      m_len = 1; m_beat = 0;
    end else begin
      m_rdy  = m_ready();
      m_pop  = (exp_q.size() != 0) && word_ready;
      m_push = 0;
      m_err  = 0;
      if (m_burst) begin
        if (!mem_busy) begin
          m_a    = m_base + 32'(4 * m_beat);
          m_ent  = {m_a, mem_word(m_a), m_beat == m_len - 1};
          m_push = 1;
          m_beat++;
          if (m_beat == m_len) m_burst = 0;
        end
      end else if (req_valid && m_rdy) begin
        if (m_bad(req_addr, req_size)) m_err = 1;
        else begin
          m_burst = 1; m_base = req_addr; m_size = req_size;
          m_len = len_of(req_size); m_beat = 0;
        end
      end
      if (m_pop) pop_log.push_back(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_ent);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (req_err) err_count++;
      chk("req_ready", 64'(req_ready), 64'(m_ready()));
      chk("req_err", 64'(req_err), 64'(m_err));
      chk("mem_enable", 64'(mem_enable), 64'(m_burst));
      chk("mem_rw", 64'(mem_rw), 64'd1);
      if (m_burst) begin
        chk("mem_address", 64'(mem_address), 64'(m_base + 32'(4 * m_beat)));
        chk("mem_access_size", 64'(mem_access_size), 64'(m_size));
      end
      chk("word_valid", 64'(word_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("word_addr", 64'(word_addr), 64'(exp_q[0][64:33]));
        chk("word_data", 64'(word_data), 64'(exp_q[0][32:1]));
        chk("word_last", 64'(word_last), 64'(exp_q[0][0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] s);
    req_valid = 1'b1; req_addr = a; req_size = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ready) begin
        tick();
        req_valid = 1'b0;
        return;
      end
    end
    n_vec++; n_bad++;
    $display("FAIL issue_timeout: got no req_ready expected acceptance of %0h", a);
    req_valid = 1'b0;
    tick();
  endtask

  task automatic burst_cycles(input logic [31:0] pat, output int en);
    en = 0;
    for (int k = 0; k < 32; k++) begin
      mem_busy = pat[k];
      @(negedge clock);
      if (!mem_enable) break;
      en++;
      tick();
    end
    tick();
    mem_busy = 1'b0;
  endtask

  task automatic drain(input int n);
    word_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int en;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = 2'd0;
    mem_busy = 1'b0; word_ready = 1'b1;
    #1 reset = 1'b1;
    #11;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_req_err", 64'(req_err), 64'd0);
    chk("rst_mem_enable", 64'(mem_enable), 64'd0);
    chk("rst_mem_rw", 64'(mem_rw), 64'd1);
    chk("rst_mem_address", 64'(mem_address), 64'h80020000);
    chk("rst_mem_size", 64'(mem_access_size), 64'd0);
    chk("rst_word_valid", 64'(word_valid), 64'd0);
    chk("rst_word_data", 64'(word_data), 64'd0);
    chk("rst_word_addr", 64'(word_addr), 64'd0);
    chk("rst_word_last", 64'(word_last), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    tick();

    // single word: two edges from accept to first word
    issue(32'h80020000, 2'd0);
    @(negedge clock);
    chk("t1_enable_beat0", 64'(mem_enable), 64'd1);
    chk("t1_valid_early", 64'(word_valid), 64'd0);
    chk("t1_addr_out", 64'(mem_address), 64'h80020000);
    tick();
    @(negedge clock);
    chk("t1_enable_off", 64'(mem_enable), 64'd0);
    chk("t1_valid", 64'(word_valid), 64'd1);
    chk("t1_data", 64'(word_data), 64'hDEADBEEF);
    chk("t1_addr", 64'(word_addr), 64'h80020000);
    chk("t1_last", 64'(word_last), 64'd1);
    tick();

    // 16-word burst, no stalls
    pop_log.delete();
    issue(32'h80020040, 2'd3);
    burst_cycles(32'h0, en);
    chk("t2_enable_cycles", 64'(en), 64'd16);
    drain(4);
    chk("t2_words", 64'(pop_log.size()), 64'd16);
    for (int i = 0; i < pop_log.size(); i++) begin
      chk("t2_seq_addr", 64'(pop_log[i][64:33]), 64'(32'h80020040 + 32'(4 * i)));
      chk("t2_seq_last", 64'(pop_log[i][0]), 64'(i == 15));
    end

    // 8-word burst stalled on beats 2 and 5
    pop_log.delete();
    issue(32'h80020100, 2'd2);
    burst_cycles(32'h44, en);
    chk("t3_enable_cycles", 64'(en), 64'd10);
    drain(4);
    chk("t3_words", 64'(pop_log.size()), 64'd8);

    // rejected requests: misaligned, below range, past end; then exact end accepted
    err_count = 0;
    issue(32'h80020002, 2'd1);
    burst_cycles(32'h0, en);
    chk("t4_misaligned_en", 64'(en), 64'd0);
    chk("t4_misaligned_err", 64'(err_count), 64'd1);
    issue(32'h8001FFFC, 2'd0);
    burst_cycles(32'h0, en);
    chk("t4_below_en", 64'(en), 64'd0);
    chk("t4_below_err", 64'(err_count), 64'd2);
    issue(32'h8011FFF0, 2'd3);
    burst_cycles(32'h0, en);
    chk("t4_over_en", 64'(en), 64'd0);
    chk("t4_over_err", 64'(err_count), 64'd3);
    chk("t4_fifo_empty", 64'(word_valid), 64'd0);
    issue(32'h8011FFC0, 2'd3);
    burst_cycles(32'h0, en);
    chk("t4_edge_en", 64'(en), 64'd16);
    chk("t4_edge_err", 64'(err_count), 64'd3);
    drain(4);

    // consumer stalled: two full bursts fill the FIFO, third request waits for a pop
    pop_log.delete();
    word_ready = 1'b0;
    issue(32'h80020200, 2'd3);
    burst_cycles(32'h0, en);
    issue(32'h80020300, 2'd3);
    burst_cycles(32'h0, en);
    req_valid = 1'b1; req_addr = 32'h80020400; req_size = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t5_ready_full", 64'(req_ready), 64'd0);
      tick();
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    @(negedge clock);
    chk("t5_ready_after_pop", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    drain(40);
    chk("t5_words", 64'(pop_log.size()), 64'd33);
    for (int i = 0; i < pop_log.size(); i++) begin
      chk("t5_order", 64'(pop_log[i][64:33]),
          (i < 16) ? 64'(32'h80020200 + 32'(4 * i)) :
          (i < 32) ? 64'(32'h80020300 + 32'(4 * (i - 16))) : 64'h80020400);
    end

    // reset mid-burst, then a clean 4-word burst
    issue(32'h80020500, 2'd3);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_enable", 64'(mem_enable), 64'd0);
    chk("t6_rst_valid", 64'(word_valid), 64'd0);
    chk("t6_rst_address", 64'(mem_address), 64'h80020000);
    chk("t6_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clock); #1 reset = 1'b0;
    tick();
    pop_log.delete();
    issue(32'h80020600, 2'd1);
    burst_cycles(32'h0, en);
    chk("t6_enable_cycles", 64'(en), 64'd4);
    drain(6);
    chk("t6_words", 64'(pop_log.size()), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
